// File: rtl/moore_pkg.sv
// Shared definitions for the Moore bit-source transmitter.
//   state_t    : FSM state codes, fixed 3-bit encoding (also exported on st)
//   ST_W       : width of the state code
//   IDLE_LEVEL : level driven on a_out whenever no frame bit is present
package moore_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic IDLE_LEVEL = 1'b0;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_PAR   = 3'd2,
    ST_GAP   = 3'd3
  } state_t;

endpackage

// File: rtl/moore_bit_source_if.sv
// Word handshake between a sender and moore_bit_source.
//   data_in   : word to transmit (sender -> source)
//   valid_in  : data_in valid, held until accepted (sender -> source)
//   ready_out : source can accept a word this cycle (source -> sender)
// Modports: master = word sender, slave = moore_bit_source.
interface moore_bit_source_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );

endinterface

// File: rtl/moore_piso_shreg.sv
// Parallel-in serial-out shift register for moore_bit_source.
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low; clears the register
//   load    : capture data_in
//   shift   : advance one bit towards the serial end
//   data_in : parallel word
//   ser_out : the bit that follows the one currently on the line
// The word is rotated rather than shifted so the register keeps its full
// contents; ser_out therefore looks one position past the head.
module moore_piso_shreg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= data_in;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr <= {sr[WIDTH-2:0], sr[WIDTH-1]};
      end else begin
        sr <= {sr[0], sr[WIDTH-1:1]};
      end
    end
  end

  assign ser_out = MSB_FIRST ? sr[WIDTH-2] : sr[1];

endmodule

// File: rtl/moore_bit_source.sv
// Serial bit-stream transmitter feeding the a_in input of the Moore
// sequence detectors. Words arrive over a valid/ready handshake, leave one
// bit per clock on a_out, and each frame is followed by an idle gap.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low
//   bus       : word handshake (data_in / valid_in / ready_out), slave side
//   a_out     : serial bit, IDLE_LEVEL when not transmitting
//   a_valid   : a_out carries a frame bit (data or parity)
//   busy      : FSM is not in ST_IDLE
//   st        : current state code
// Build option: define MOORE_SRC_PARITY_EN to append an even-parity bit
// (ST_PAR) after the data bits; otherwise ST_PAR logic is not built.
// Every output is a register updated together with the state.
module moore_bit_source
  import moore_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  moore_bit_source_if.slave bus,
  output logic            a_out,
  output logic            a_valid,
  output logic            busy,
  output logic [ST_W-1:0] st
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam bit            GAP_ONE  = (GAP_CYCLES == 1);

  state_t        state;
  logic          ready_q;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          accept;
  logic          shift;
  logic          ser_next;
  logic          first_bit;

`ifdef MOORE_SRC_PARITY_EN
  logic par_q;
`endif

  assign accept        = bus.valid_in & ready_q;
  assign bus.ready_out = ready_q;
  assign shift         = (state == ST_SHIFT) && (bit_cnt != BIT_LAST);
  assign first_bit     = MSB_FIRST ? bus.data_in[WIDTH-1] : bus.data_in[0];
  assign st            = state;

  moore_piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .shift   (shift),
    .data_in (bus.data_in),
    .ser_out (ser_next)
  );

`ifdef MOORE_SRC_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^bus.data_in;
    end
  end
`endif

  // accept can only be high in ST_IDLE or the last ST_GAP cycle (the only
  // places ready_q is set), so frame start is handled once ahead of the
  // per-state case instead of being duplicated in both states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
      a_out   <= IDLE_LEVEL;
      a_valid <= 1'b0;
      busy    <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else if (accept) begin
      state   <= ST_SHIFT;
      ready_q <= 1'b0;
      a_out   <= first_bit;
      a_valid <= 1'b1;
      busy    <= 1'b1;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
        end

        ST_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
`ifdef MOORE_SRC_PARITY_EN
            state   <= ST_PAR;
            a_out   <= par_q;
            a_valid <= 1'b1;
`else
            state   <= ST_GAP;
            gap_cnt <= '0;
            a_out   <= IDLE_LEVEL;
            a_valid <= 1'b0;
            ready_q <= GAP_ONE;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            a_out   <= ser_next;
          end
        end

`ifdef MOORE_SRC_PARITY_EN
        ST_PAR: begin
          state   <= ST_GAP;
          gap_cnt <= '0;
          a_out   <= IDLE_LEVEL;
          a_valid <= 1'b0;
          ready_q <= GAP_ONE;
        end
`endif

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            ready_q <= ((gap_cnt + 1'b1) == GAP_LAST);
          end
        end

        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
          a_out   <= IDLE_LEVEL;
          a_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_bit_source.sv
// Self-checking bench for moore_bit_source (WIDTH=8, GAP_CYCLES=1,
// MSB_FIRST=1). Accepted words push their expected serial bits into a
// queue; a negedge monitor pops one entry per a_valid cycle.
module tb_moore_bit_source;
  import moore_pkg::*;

`ifdef MOORE_SRC_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FRAME  = 9;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FRAME  = 8;
`endif
  localparam int GAP = 1;

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq;   // expected bits in emission order, leftmost first
    logic       par;   // expected parity bit (parity builds)
  } vec_t;

  logic            clk;
  logic            reset;
  logic            a_out;
  logic            a_valid;
  logic            busy;
  logic [ST_W-1:0] st;

  moore_bit_source_if #(.WIDTH(8)) bus ();

  moore_bit_source #(
    .WIDTH      (8),
    .GAP_CYCLES (1),
    .MSB_FIRST  (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .a_out   (a_out),
    .a_valid (a_valid),
    .busy    (busy),
    .st      (st)
  );

  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   chk_busy = 1'b0;
  logic exp_q[$];
  vec_t tbl[7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame bits on a_valid; idle level otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL extra_bit: a_valid=1 with nothing expected (cycle %0d)", cyc);
        end else begin
          check("serial_bit", {31'd0, a_out}, {31'd0, exp_q.pop_front()});
        end
      end else begin
        check("idle_a_valid", {31'd0, a_valid}, 32'd0);
        check("idle_a_out", {31'd0, a_out}, 32'd0);
      end
      if (chk_busy) check("busy_held", {31'd0, busy}, 32'd1);
    end
  end

  // Must be called just after a rising edge. Returns the cycle count of the
  // accepting edge.
  task automatic send(input logic [7:0] w, input logic [7:0] seq, input logic par,
                      input bit keep, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    bus.data_in  = w;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.ready_out === 1'b1) begin
        for (int b = 7; b >= 0; b--) exp_q.push_back(seq[b]);
        if (PAR_EN) exp_q.push_back(par);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep) bus.valid_in = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      nvec++;
      nfail++;
      $display("FAIL accept_timeout: word %0h never accepted, expected accept within 64 cycles", w);
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 32'd0);
  endtask

  int a1, a2;

  initial begin
    tbl[0] = '{word: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
    tbl[1] = '{word: 8'h3C, seq: 8'b0011_1100, par: 1'b0};
    tbl[2] = '{word: 8'h0F, seq: 8'b0000_1111, par: 1'b0};
    tbl[3] = '{word: 8'h00, seq: 8'b0000_0000, par: 1'b0};
    tbl[4] = '{word: 8'hFF, seq: 8'b1111_1111, par: 1'b0};
    tbl[5] = '{word: 8'h80, seq: 8'b1000_0000, par: 1'b1};
    tbl[6] = '{word: 8'h01, seq: 8'b0000_0001, par: 1'b1};

    // Reset state
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    #2 reset = 1'b0;
    #1;
    mon_en = 1'b1;
    check("rst_ready", {31'd0, bus.ready_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_st", {29'd0, st}, 32'd0);
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    check("ready_before_edge", {31'd0, bus.ready_out}, 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_release", {31'd0, bus.ready_out}, 32'd1);
    check("st_after_release", {29'd0, st}, 32'd0);

    // Single frames from idle
    foreach (tbl[i]) begin
      send(tbl[i].word, tbl[i].seq, tbl[i].par, 1'b0, a1);
      check("st_shift", {29'd0, st}, 32'd1);
      check("busy_shift", {31'd0, busy}, 32'd1);
      check("ready_shift", {31'd0, bus.ready_out}, 32'd0);
      repeat (FRAME) @(posedge clk);
      #1;
      check("gap_a_valid", {31'd0, a_valid}, 32'd0);
      check("gap_ready", {31'd0, bus.ready_out}, 32'd1);
      check("gap_st", {29'd0, st}, 32'd3);
      check("frame_len", exp_q.size(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("idle_st", {29'd0, st}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_ready", {31'd0, bus.ready_out}, 32'd1);
    end

    // Back-to-back A5 then 3C, valid held high
    send(8'hA5, 8'b1010_0101, 1'b0, 1'b1, a1);
    chk_busy = 1'b1;
    send(8'h3C, 8'b0011_1100, 1'b0, 1'b0, a2);
    check("b2b_spacing", a2 - a1, FRAME + GAP);
    repeat (FRAME) @(posedge clk);
    #1;
    chk_busy = 1'b0;
    drain("b2b_drain");
    repeat (2) @(posedge clk);
    #1;

    // FF offered during the 0F frame must wait for the gap cycle
    send(8'h0F, 8'b0000_1111, 1'b0, 1'b1, a1);
    send(8'hFF, 8'b1111_1111, 1'b0, 1'b0, a2);
    check("held_spacing", a2 - a1, FRAME + GAP);
    drain("held_drain");
    repeat (3) @(posedge clk);
    #1;

    // Reset during bit 3 of A5
    send(8'hA5, 8'b1010_0101, 1'b0, 1'b0, a1);
    repeat (3) @(posedge clk);
    #2;
    check("pre_abort_valid", {31'd0, a_valid}, 32'd1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_a_out", {31'd0, a_out}, 32'd0);
    check("abort_a_valid", {31'd0, a_valid}, 32'd0);
    check("abort_st", {29'd0, st}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, bus.ready_out}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    check("abort_ready_pre", {31'd0, bus.ready_out}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_ready_post", {31'd0, bus.ready_out}, 32'd1);
    send(8'h3C, 8'b0011_1100, 1'b0, 1'b0, a1);
    drain("post_abort_drain");

    // Parity pair (second word has odd population)
    repeat (2) @(posedge clk);
    #1;
    send(8'hA5, 8'b1010_0101, 1'b0, 1'b1, a1);
    send(8'h07, 8'b0000_0111, 1'b1, 1'b0, a2);
    check("par_spacing", a2 - a1, FRAME + GAP);
    drain("par_drain");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
